deck_shuffler: RTL and testbench



---
 rtl/deck_shuffler.sv | 185 ++++++++++++++++++
 tb/tb_deck_shuffler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/deck_shuffler.sv
// 52-card deck with an in-place Fisher-Yates shuffle driven by a free-running 16-bit LFSR.
// The SWAP pass is compiled only when DECK_SHUFFLE_EN is defined; otherwise the deck deals in identity order.

package poker_types_pkg;
  typedef enum logic [1:0] {CLUBS, DIAMONDS, HEARTS, SPADES} suit_t;
  typedef enum logic [3:0] {
    TWO, THREE, FOUR, FIVE, SIX, SEVEN, EIGHT, NINE, TEN, JACK, QUEEN, KING, ACE
  } rank_t;
  typedef struct packed {
    suit_t suit;
    rank_t rank;
  } card_t;
endpackage

module deck_shuffler
  import poker_types_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_shuffle,
  input  logic       draw_card,
  output card_t      top_card,
  output logic       is_shuffled,
  output logic [5:0] cards_remaining,
  output logic       empty
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
`ifdef DECK_SHUFFLE_EN
    S_SWAP,
`endif
    S_READY
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  deck_q [0:51];
  logic [5:0]  deck_d [0:51];
  logic [5:0]  ptr_q, ptr_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        load_identity;
  logic [5:0]  top_idx;
  logic [3:0]  rank_base;
  suit_t       top_suit;

`ifdef DECK_SHUFFLE_EN
  logic [5:0]  i_q, i_d;
  logic [5:0]  mask;
  logic [5:0]  m;
  logic [5:0]  j;
  logic        swap_en;

  // Smearing i gives the smallest all-ones mask >= i, i.e. 2^k - 1 with 2^k >= i+1.
  always_comb begin
    mask = i_q | (i_q >> 1) | (i_q >> 2) | (i_q >> 3) | (i_q >> 4) | (i_q >> 5);
    m    = lfsr_q[5:0] & mask;
    j    = (m > i_q) ? (m - i_q - 6'd1) : m;
  end
`endif

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    load_identity = 1'b0;
`ifdef DECK_SHUFFLE_EN
    i_d           = i_q;
    swap_en       = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_INIT: begin
        load_identity = 1'b1;
        ptr_d         = 6'd0;
`ifdef DECK_SHUFFLE_EN
        i_d           = 6'd51;
        state_d       = S_SWAP;
`else
        state_d       = S_READY;
`endif
      end
`ifdef DECK_SHUFFLE_EN
      S_SWAP: begin
        swap_en = 1'b1;
        i_d     = i_q - 6'd1;
        if (i_q == 6'd1) begin
          state_d = S_READY;
        end
      end
`endif
      S_READY: begin
        if (draw_card && (ptr_q < 6'd52)) begin
          ptr_d = ptr_q + 6'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A restart outranks everything else this cycle, including a pending draw.
    if (start_shuffle) begin
      state_d = S_INIT;
      ptr_d   = ptr_q;
    end
  end

  always_comb begin
    for (int n = 0; n < 52; n++) begin
      deck_d[n] = deck_q[n];
      if (load_identity) begin
        deck_d[n] = 6'(n);
      end
`ifdef DECK_SHUFFLE_EN
      else if (swap_en) begin
        if (i_q == 6'(n)) begin
          deck_d[n] = deck_q[j];
        end else if (j == 6'(n)) begin
          deck_d[n] = deck_q[i_q];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 6'd0;
      lfsr_q  <= LFSR_SEED;
      for (int n = 0; n < 52; n++) begin
        deck_q[n] <= 6'(n);
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lfsr_q  <= lfsr_d;
      for (int n = 0; n < 52; n++) begin
        deck_q[n] <= deck_d[n];
      end
    end
  end

`ifdef DECK_SHUFFLE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      i_q <= 6'd51;
    end else begin
      i_q <= i_d;
    end
  end
`endif

  // Rank is index minus the suit base; only the low nibble matters since the result is < 13.
  always_comb begin
    top_idx = (ptr_q == 6'd52) ? deck_q[51] : deck_q[ptr_q];
    if (top_idx >= 6'd39) begin
      top_suit  = SPADES;
      rank_base = 4'd7;
    end else if (top_idx >= 6'd26) begin
      top_suit  = HEARTS;
      rank_base = 4'd10;
    end else if (top_idx >= 6'd13) begin
      top_suit  = DIAMONDS;
      rank_base = 4'd13;
    end else begin
      top_suit  = CLUBS;
      rank_base = 4'd0;
    end
    top_card.suit = top_suit;
    top_card.rank = rank_t'(top_idx[3:0] - rank_base);
  end

  assign is_shuffled     = (state_q == S_READY);
  assign cards_remaining = 6'd52 - ptr_q;
  assign empty           = (ptr_q == 6'd52);

endmodule

// File: tb/tb_deck_shuffler.sv
// Directed bench for deck_shuffler: reset, dealing, shuffle order vs a reference model, restart and start/draw collisions.
// Shuffle-order scenarios run only when DECK_SHUFFLE_EN is defined.

module tb_deck_shuffler;
  import poker_types_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
`ifdef DECK_SHUFFLE_EN
  localparam int EXP_LOW = 52;
`else
  localparam int EXP_LOW = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_shuffle = 1'b0;
  logic       draw_card = 1'b0;
  card_t      top_card;
  logic       is_shuffled;
  logic [5:0] cards_remaining;
  logic       empty;

  always #5 clk = ~clk;

  deck_shuffler #(.LFSR_SEED(SEED)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_shuffle   (start_shuffle),
    .draw_card       (draw_card),
    .top_card        (top_card),
    .is_shuffled     (is_shuffled),
    .cards_remaining (cards_remaining),
    .empty           (empty)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic int card_idx(input card_t c);
    return int'(c.suit) * 13 + int'(c.rank);
  endfunction

  // Expected LFSR value, advanced on every clock from reset just like the spec says.
  logic [15:0] lfsr_m;
  always @(posedge clk) lfsr_m <= reset ? SEED : lfsr_step(lfsr_m);

  int errors = 0;
  int checks = 0;
  int exp_deck [52];
  int obs_top [52];
  int obs_rem [52];
  int first_order [52];
  logic [15:0] l0;
  int low;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_shuffle = 1'b0;
    draw_card = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start_shuffle = 1'b1;
    tick();
    start_shuffle = 1'b0;
  endtask

  // Called just after the start edge; counts low observations and captures the first-swap LFSR value.
  task automatic wait_ready();
    low = 0;
    l0 = '0;
    for (int c = 0; c < 200; c++) begin
      if (c == 1) l0 = lfsr_m;
      if (is_shuffled) break;
      low++;
      tick();
    end
  endtask

  task automatic build_model(input logic [15:0] seed_at_swap);
    logic [15:0] l;
    int k, m, jj, t;
    for (int n = 0; n < 52; n++) exp_deck[n] = n;
`ifdef DECK_SHUFFLE_EN
    l = seed_at_swap;
    for (int i = 51; i >= 1; i--) begin
      k = $clog2(i + 1);
      m = int'(l) % (1 << k);
      jj = (m >= i + 1) ? m - (i + 1) : m;
      t = exp_deck[i];
      exp_deck[i] = exp_deck[jj];
      exp_deck[jj] = t;
      l = lfsr_step(l);
    end
`else
    l = seed_at_swap;
    if (l == 16'h0) t = 0;
`endif
  endtask

  task automatic draw_all();
    draw_card = 1'b1;
    for (int p = 0; p < 52; p++) begin
      obs_top[p] = card_idx(top_card);
      obs_rem[p] = int'(cards_remaining);
      tick();
    end
    draw_card = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (is_shuffled !== 1'b0) begin errors++; $display("FAIL reset_is_shuffled: got %0b want 0", is_shuffled); end
    checks++; if (cards_remaining !== 6'd52) begin errors++; $display("FAIL reset_remaining: got %0d want 52", cards_remaining); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL reset_empty: got %0b want 0", empty); end
    checks++; if (card_idx(top_card) != 0) begin errors++; $display("FAIL reset_top: got %0d want 0", card_idx(top_card)); end
    draw_card = 1'b1;
    tick();
    draw_card = 1'b0;
    checks++; if (cards_remaining !== 6'd52) begin errors++; $display("FAIL idle_draw_remaining: got %0d want 52", cards_remaining); end
    checks++; if (card_idx(top_card) != 0) begin errors++; $display("FAIL idle_draw_top: got %0d want 0", card_idx(top_card)); end
    $display("test_reset: done, errors so far %0d", errors);
  endtask

  task automatic test_deal();
    logic [51:0] seen;
    int bad;
    do_reset();
    pulse_start();
    wait_ready();
    checks++; if (low != EXP_LOW) begin errors++; $display("FAIL deal_latency: low for %0d cycles want %0d", low, EXP_LOW); end
    build_model(l0);
    draw_all();
    for (int p = 0; p < 52; p++) begin
      checks++; if (obs_top[p] != exp_deck[p]) begin errors++; $display("FAIL deal_top[%0d]: got %0d want %0d", p, obs_top[p], exp_deck[p]); end
      checks++; if (obs_rem[p] != 52 - p) begin errors++; $display("FAIL deal_remaining[%0d]: got %0d want %0d", p, obs_rem[p], 52 - p); end
    end
    seen = '0; bad = 0;
    for (int p = 0; p < 52; p++) begin
      if (obs_top[p] < 0 || obs_top[p] > 51 || seen[obs_top[p]]) bad++;
      else seen[obs_top[p]] = 1'b1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL deal_permutation: got %0d bad entries want 0", bad); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL deal_empty: got %0b want 1", empty); end
    checks++; if (cards_remaining !== 6'd0) begin errors++; $display("FAIL deal_remaining_end: got %0d want 0", cards_remaining); end
    checks++; if (card_idx(top_card) != exp_deck[51]) begin errors++; $display("FAIL deal_top_end: got %0d want %0d", card_idx(top_card), exp_deck[51]); end
    draw_card = 1'b1;
    tick();
    draw_card = 1'b0;
    checks++; if (card_idx(top_card) != exp_deck[51]) begin errors++; $display("FAIL extra_draw_top: got %0d want %0d", card_idx(top_card), exp_deck[51]); end
    checks++; if (cards_remaining !== 6'd0) begin errors++; $display("FAIL extra_draw_remaining: got %0d want 0", cards_remaining); end
    $display("test_deal: latency %0d, first card %0d, errors so far %0d", low, obs_top[0], errors);
  endtask

`ifdef DECK_SHUFFLE_EN
  task automatic test_gaps();
    logic [51:0] seen;
    int bad, diffs;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      repeat (10 + run) tick();
      pulse_start();
      wait_ready();
      checks++; if (low != 52) begin errors++; $display("FAIL gap%0d_latency: low for %0d want 52", run, low); end
      build_model(l0);
      draw_all();
      bad = 0;
      for (int p = 0; p < 52; p++) if (obs_top[p] != exp_deck[p]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL gap%0d_model: got %0d mismatched positions want 0", run, bad); end
      seen = '0; bad = 0;
      for (int p = 0; p < 52; p++) begin
        if (obs_top[p] < 0 || obs_top[p] > 51 || seen[obs_top[p]]) bad++;
        else seen[obs_top[p]] = 1'b1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL gap%0d_permutation: got %0d bad entries want 0", run, bad); end
      if (run == 0) for (int p = 0; p < 52; p++) first_order[p] = obs_top[p];
    end
    diffs = 0;
    for (int p = 0; p < 52; p++) if (first_order[p] != obs_top[p]) diffs++;
    checks++; if (diffs == 0) begin errors++; $display("FAIL gap_orders_differ: got %0d differing positions want >0", diffs); end
    $display("test_gaps: orders differ in %0d positions, errors so far %0d", diffs, errors);
  endtask

  task automatic test_restart();
    logic [51:0] seen;
    int bad;
    do_reset();
    pulse_start();
    draw_card = 1'b1;
    repeat (20) tick();
    draw_card = 1'b0;
    checks++; if (is_shuffled !== 1'b0) begin errors++; $display("FAIL restart_mid_swap: got %0b want 0", is_shuffled); end
    pulse_start();
    checks++; if (is_shuffled !== 1'b0) begin errors++; $display("FAIL restart_after_pulse: got %0b want 0", is_shuffled); end
    wait_ready();
    checks++; if (low != 52) begin errors++; $display("FAIL restart_latency: low for %0d want 52", low); end
    checks++; if (cards_remaining !== 6'd52) begin errors++; $display("FAIL restart_remaining: got %0d want 52", cards_remaining); end
    build_model(l0);
    draw_all();
    bad = 0;
    for (int p = 0; p < 52; p++) if (obs_top[p] != exp_deck[p]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_model: got %0d mismatched positions want 0", bad); end
    seen = '0; bad = 0;
    for (int p = 0; p < 52; p++) begin
      if (obs_top[p] < 0 || obs_top[p] > 51 || seen[obs_top[p]]) bad++;
      else seen[obs_top[p]] = 1'b1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_permutation: got %0d bad entries want 0", bad); end
    $display("test_restart: latency %0d, errors so far %0d", low, errors);
  endtask
`endif

  task automatic test_start_with_draw();
    do_reset();
    pulse_start();
    wait_ready();
    draw_card = 1'b1;
    repeat (3) tick();
    draw_card = 1'b0;
    checks++; if (cards_remaining !== 6'd49) begin errors++; $display("FAIL collide_predraw: got %0d want 49", cards_remaining); end
    start_shuffle = 1'b1;
    draw_card = 1'b1;
    tick();
    start_shuffle = 1'b0;
    draw_card = 1'b0;
    checks++; if (is_shuffled !== 1'b0) begin errors++; $display("FAIL collide_is_shuffled: got %0b want 0", is_shuffled); end
    checks++; if (cards_remaining !== 6'd49) begin errors++; $display("FAIL collide_draw_dropped: got %0d want 49", cards_remaining); end
    wait_ready();
    checks++; if (low != EXP_LOW) begin errors++; $display("FAIL collide_latency: low for %0d want %0d", low, EXP_LOW); end
    build_model(l0);
    checks++; if (cards_remaining !== 6'd52) begin errors++; $display("FAIL collide_remaining: got %0d want 52", cards_remaining); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL collide_empty: got %0b want 0", empty); end
    checks++; if (card_idx(top_card) != exp_deck[0]) begin errors++; $display("FAIL collide_top: got %0d want %0d", card_idx(top_card), exp_deck[0]); end
    $display("test_start_with_draw: remaining %0d, errors so far %0d", cards_remaining, errors);
  endtask

  task automatic test_reset_mid();
    do_reset();
    pulse_start();
    repeat (5) tick();
    draw_card = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    draw_card = 1'b0;
    checks++; if (is_shuffled !== 1'b0) begin errors++; $display("FAIL midreset_is_shuffled: got %0b want 0", is_shuffled); end
    checks++; if (cards_remaining !== 6'd52) begin errors++; $display("FAIL midreset_remaining: got %0d want 52", cards_remaining); end
    checks++; if (card_idx(top_card) != 0) begin errors++; $display("FAIL midreset_top: got %0d want 0", card_idx(top_card)); end
    repeat (60) tick();
    checks++; if (is_shuffled !== 1'b0) begin errors++; $display("FAIL midreset_stays_idle: got %0b want 0", is_shuffled); end
    $display("test_reset_mid: errors so far %0d", errors);
  endtask

  initial begin
    test_reset();
    test_deal();
`ifdef DECK_SHUFFLE_EN
    test_gaps();
    test_restart();
`endif
    test_start_with_draw();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
